// File: rtl/fma16_pkg.sv
// Shared types and bit positions for the fma16 request arbiter.
package fma16_pkg;

  // Arbiter control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Bit positions inside the 4-bit op field {mul, add, negp, negz}.
  localparam int OP_MUL  = 3;
  localparam int OP_ADD  = 2;
  localparam int OP_NEGP = 1;
  localparam int OP_NEGZ = 0;

  // Bit positions inside the 4-bit flag field {invalid, overflow, underflow, inexact}.
  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  // One complete operation as presented to the datapath.
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic [3:0]  op;
  } operand_t;

endpackage

// File: rtl/fma16_arb_rr.sv
// Two-way round-robin grant: a lone valid requester always wins; with both
// valid, the one that was not granted last wins.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant
);

  // Grant decode from the valid pair and the last-granted index.
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/fma16_arb.sv
// fma16_arb: two-requester round-robin front end for a shared external
// combinational fma16 datapath. One operation is in flight at a time: the
// winner's operands are registered, held on dp_* for LATENCY cycles, and the
// datapath output is then captured and presented until the consumer takes it.
//
// state | meaning
// IDLE  | arbitrating; dp_* keep the last captured operands
// BUSY  | operands held on dp_*; counter runs down to zero
// RESP  | response registered and offered on rsp_*
module fma16_arb
  import fma16_pkg::*;
#(
  parameter int LATENCY = 2  // legal range 1..15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_x,
  input  logic [15:0] req0_y,
  input  logic [15:0] req0_z,
  input  logic [3:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_x,
  input  logic [15:0] req1_y,
  input  logic [15:0] req1_z,
  input  logic [3:0]  req1_op,
  output logic [15:0] dp_x,
  output logic [15:0] dp_y,
  output logic [15:0] dp_z,
  output logic [3:0]  dp_op,
  input  logic [15:0] dp_result,
  input  logic [3:0]  dp_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic        rsp_id
);

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] cnt;
  logic       last;
  logic [1:0] grant;
  logic       accept;
  logic       busy_done;
  operand_t   req0_opnd;
  operand_t   req1_opnd;
  operand_t   opnd_q;
  logic       id_q;

  assign req0_opnd = {req0_x, req0_y, req0_z, req0_op};
  assign req1_opnd = {req1_x, req1_y, req1_z, req1_op};

  rr_arb2 u_rr (
    .valid ({req1_valid, req0_valid}),
    .last  (last),
    .grant (grant)
  );

  assign accept    = (state == IDLE) && (grant != 2'b00);
  assign busy_done = (state == BUSY) && (cnt == 4'd0);

  assign dp_x  = opnd_q.x;
  assign dp_y  = opnd_q.y;
  assign dp_z  = opnd_q.z;
  assign dp_op = opnd_q.op;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)    state_next = BUSY;
      BUSY:    if (busy_done) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs; readies only ever assert while arbitrating, so a
  // response handshake can never coincide with a new accept.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = grant[0];
        req1_ready = grant[1];
      end
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Busy-window down-counter: loaded on accept, terminal count ends BUSY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 4'd0;
    end else if (accept) begin
      cnt <= CNT_LOAD;
    end else if ((state == BUSY) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Operand, id and round-robin pointer capture on accept. The pointer
  // resets to 1 so that req0 is favoured first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opnd_q <= '0;
      id_q   <= 1'b0;
      last   <= 1'b1;
    end else if (accept) begin
      opnd_q <= grant[1] ? req1_opnd : req0_opnd;
      id_q   <= grant[1];
      last   <= grant[1];
    end
  end

  // Response capture on the last BUSY edge; held through RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_result <= 16'h0000;
      rsp_flags  <= 4'h0;
      rsp_id     <= 1'b0;
    end else if (busy_done) begin
      rsp_result <= dp_result;
      rsp_flags  <= dp_flags;
      rsp_id     <= id_q;
    end
  end

endmodule

// File: tb/tb_fma16_arb.sv
// Bench for fma16_arb: three instances (LATENCY 2, 1, 15) driven through
// directed tables, corner sequences and a random phase, all watched by a
// transaction-level reference model.
module tb_fma16_arb;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic [3:0]  op;
  } op_t;

  typedef struct {
    bit          v0;
    bit          v1;
    op_t         o0;
    op_t         o1;
    bit          exp_id;
    logic [15:0] exp_res;
    logic [3:0]  exp_fl;
  } vec_t;

  logic        clk;
  logic        reset      [3];
  logic        req0_valid [3];
  logic        req1_valid [3];
  logic        req0_ready [3];
  logic        req1_ready [3];
  op_t         req0_s     [3];
  op_t         req1_s     [3];
  logic [15:0] dp_x       [3];
  logic [15:0] dp_y       [3];
  logic [15:0] dp_z       [3];
  logic [3:0]  dp_op      [3];
  logic [15:0] dp_result  [3];
  logic [3:0]  dp_flags   [3];
  logic        rsp_valid  [3];
  logic        rsp_ready  [3];
  logic [15:0] rsp_result [3];
  logic [3:0]  rsp_flags  [3];
  logic        rsp_id     [3];

  int n_pass  = 0;
  int n_total = 0;

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : (i == 1) ? 1 : 15;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 2 : (g == 1) ? 1 : 15;
    fma16_arb #(.LATENCY(LAT)) u_dut (
      .clk        (clk),
      .reset      (reset[g]),
      .req0_valid (req0_valid[g]),
      .req0_ready (req0_ready[g]),
      .req0_x     (req0_s[g].x),
      .req0_y     (req0_s[g].y),
      .req0_z     (req0_s[g].z),
      .req0_op    (req0_s[g].op),
      .req1_valid (req1_valid[g]),
      .req1_ready (req1_ready[g]),
      .req1_x     (req1_s[g].x),
      .req1_y     (req1_s[g].y),
      .req1_z     (req1_s[g].z),
      .req1_op    (req1_s[g].op),
      .dp_x       (dp_x[g]),
      .dp_y       (dp_y[g]),
      .dp_z       (dp_z[g]),
      .dp_op      (dp_op[g]),
      .dp_result  (dp_result[g]),
      .dp_flags   (dp_flags[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_ready  (rsp_ready[g]),
      .rsp_result (rsp_result[g]),
      .rsp_flags  (rsp_flags[g]),
      .rsp_id     (rsp_id[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in datapath: a cheap deterministic function of the operands that
  // only becomes correct once the operands have been stable for LATENCY cycles.
  function automatic logic [15:0] f_res(input op_t o);
    return o.x ^ o.y ^ o.z ^ (o.op[3] ? 16'h0200 : 16'h0000);
  endfunction

  function automatic logic [3:0] f_flg(input op_t o);
    return o.x[3:0] ^ o.y[3:0] ^ o.z[3:0];
  endfunction

  int  age     [3] = '{0, 0, 0};
  op_t dp_prev [3] = '{'0, '0, '0};

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      op_t cur;
      cur = {dp_x[i], dp_y[i], dp_z[i], dp_op[i]};
      if (cur == dp_prev[i]) begin
        if (age[i] < 1000) age[i] = age[i] + 1;
      end else begin
        age[i] = 1;
      end
      dp_prev[i] = cur;
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      op_t cur;
      cur = {dp_x[i], dp_y[i], dp_z[i], dp_op[i]};
      dp_result[i] = (age[i] >= lat_of(i)) ? f_res(cur) : ~f_res(cur);
      dp_flags[i]  = (age[i] >= lat_of(i)) ? f_flg(cur) : ~f_flg(cur);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: phase 0 free, 1 holding operands, 2 offering a response.
  int  m_phase [3] = '{0, 0, 0};
  int  m_cnt   [3] = '{0, 0, 0};
  bit  m_last  [3] = '{1'b1, 1'b1, 1'b1};
  bit  m_id    [3] = '{1'b0, 1'b0, 1'b0};
  op_t m_ops   [3] = '{'0, '0, '0};

  task automatic model_step(input int i);
    bit  g0, g1;
    op_t dp_now;
    dp_now = {dp_x[i], dp_y[i], dp_z[i], dp_op[i]};
    case (m_phase[i])
      0: begin
        g0 = req0_valid[i] && (!req1_valid[i] || m_last[i]);
        g1 = req1_valid[i] && !g0;
        chk($sformatf("i%0d_idle_ready0", i), 64'(req0_ready[i]), 64'(g0));
        chk($sformatf("i%0d_idle_ready1", i), 64'(req1_ready[i]), 64'(g1));
        chk($sformatf("i%0d_idle_rsp_valid", i), 64'(rsp_valid[i]), 64'(0));
        chk($sformatf("i%0d_idle_dp_hold", i), 64'(dp_now), 64'(m_ops[i]));
        if (g0 || g1) begin
          m_ops[i]   = g1 ? req1_s[i] : req0_s[i];
          m_id[i]    = g1;
          m_last[i]  = g1;
          m_cnt[i]   = lat_of(i);
          m_phase[i] = 1;
        end
      end
      1: begin
        chk($sformatf("i%0d_busy_ready", i), 64'({req1_ready[i], req0_ready[i]}), 64'(0));
        chk($sformatf("i%0d_busy_rsp_valid", i), 64'(rsp_valid[i]), 64'(0));
        chk($sformatf("i%0d_busy_dp_stable", i), 64'(dp_now), 64'(m_ops[i]));
        m_cnt[i] = m_cnt[i] - 1;
        if (m_cnt[i] == 0) m_phase[i] = 2;
      end
      default: begin
        chk($sformatf("i%0d_resp_valid", i), 64'(rsp_valid[i]), 64'(1));
        chk($sformatf("i%0d_resp_result", i), 64'(rsp_result[i]), 64'(f_res(m_ops[i])));
        chk($sformatf("i%0d_resp_flags", i), 64'(rsp_flags[i]), 64'(f_flg(m_ops[i])));
        chk($sformatf("i%0d_resp_id", i), 64'(rsp_id[i]), 64'(m_id[i]));
        chk($sformatf("i%0d_resp_ready", i), 64'({req1_ready[i], req0_ready[i]}), 64'(0));
        if (rsp_ready[i]) m_phase[i] = 0;
      end
    endcase
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset[i]) begin
        m_phase[i] = 0;
        m_last[i]  = 1'b1;
        m_id[i]    = 1'b0;
        m_ops[i]   = '0;
      end else begin
        model_step(i);
      end
    end
  end

  task automatic chk_zero(input int i, input string tag);
    chk($sformatf("%s_rsp_zero", tag),
        64'({rsp_valid[i], rsp_id[i], rsp_flags[i], rsp_result[i]}), 64'(0));
    chk($sformatf("%s_dp_zero", tag),
        64'({dp_x[i], dp_y[i], dp_z[i], dp_op[i]}), 64'(0));
  endtask

  task automatic do_reset(input int i);
    @(posedge clk); #1;
    reset[i] = 1'b1;
    @(negedge clk);
    chk_zero(i, $sformatf("i%0d_reset", i));
    @(posedge clk); #1;
    reset[i] = 1'b0;
  endtask

  task automatic do_op(input int i, input bit v0, input bit v1, input op_t o0, input op_t o1,
                       output bit id, output logic [15:0] res, output logic [3:0] fl,
                       output int acc_wait, output int lat);
    bit got;
    @(posedge clk); #1;
    req0_valid[i] = v0;
    req1_valid[i] = v1;
    req0_s[i]     = o0;
    req1_s[i]     = o1;
    rsp_ready[i]  = 1'b0;
    got = 1'b0;
    acc_wait = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      acc_wait++;
      got = (req0_valid[i] && req0_ready[i]) || (req1_valid[i] && req1_ready[i]);
    end
    chk($sformatf("i%0d_accept_seen", i), 64'(got), 64'(1));
    @(posedge clk); #1;
    req0_valid[i] = 1'b0;
    req1_valid[i] = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      lat++;
      got = rsp_valid[i];
    end
    chk($sformatf("i%0d_rsp_seen", i), 64'(got), 64'(1));
    id  = rsp_id[i];
    res = rsp_result[i];
    fl  = rsp_flags[i];
    @(posedge clk); #1;
    rsp_ready[i] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[i] = 1'b0;
  endtask

  function automatic op_t rand_op();
    op_t o;
    o.x  = 16'($urandom);
    o.y  = 16'($urandom);
    o.z  = 16'($urandom);
    o.op = 4'($urandom);
    return o;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [6];
    bit          id;
    logic [15:0] res;
    logic [3:0]  fl;
    int          acc_wait, lat;
    int          ids [$];
    logic [15:0] snap_res;
    logic [3:0]  snap_fl;
    bit          snap_id;
    bit          got, a0, a1;
    op_t         z_op;

    z_op = '0;
    vecs[0] = '{1, 0, {16'h3C00, 16'h4000, 16'h3C00, 4'hC}, z_op, 0, 16'h4200, 4'h0};
    vecs[1] = '{0, 1, z_op, {16'h1234, 16'h0001, 16'h0000, 4'h0}, 1, 16'h1235, 4'h5};
    vecs[2] = '{1, 1, {16'hAAAA, 16'h5555, 16'h0F0F, 4'h8},
                {16'h1111, 16'h2222, 16'h4444, 4'h1}, 0, 16'hF2F0, 4'h0};
    vecs[3] = '{1, 1, {16'hAAAA, 16'h5555, 16'h0F0F, 4'h8},
                {16'h1111, 16'h2222, 16'h4444, 4'h1}, 1, 16'h7777, 4'h7};
    vecs[4] = '{1, 1, {16'hAAAA, 16'h5555, 16'h0F0F, 4'h8},
                {16'h1111, 16'h2222, 16'h4444, 4'h1}, 0, 16'hF2F0, 4'h0};
    vecs[5] = '{1, 1, {16'h0000, 16'h0000, 16'h0008, 4'h4},
                {16'hFFFF, 16'h0001, 16'h0000, 4'hF}, 1, 16'hFDFE, 4'hE};

    for (int i = 0; i < 3; i++) begin
      reset[i]      = 1'b1;
      req0_valid[i] = 1'b0;
      req1_valid[i] = 1'b0;
      req0_s[i]     = '0;
      req1_s[i]     = '0;
      rsp_ready[i]  = 1'b0;
    end

    // Power-on reset state on every instance.
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) chk_zero(i, $sformatf("i%0d_por", i));
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) reset[i] = 1'b0;

    // Directed vector table on the LATENCY=2 instance.
    for (int v = 0; v < 6; v++) begin
      do_op(0, vecs[v].v0, vecs[v].v1, vecs[v].o0, vecs[v].o1, id, res, fl, acc_wait, lat);
      chk($sformatf("vec%0d_id", v), 64'(id), 64'(vecs[v].exp_id));
      chk($sformatf("vec%0d_result", v), 64'(res), 64'(vecs[v].exp_res));
      chk($sformatf("vec%0d_flags", v), 64'(fl), 64'(vecs[v].exp_fl));
      chk($sformatf("vec%0d_latency", v), 64'(lat), 64'(3));
    end

    // Both requesters valid continuously: grants alternate starting at 0.
    do_reset(0);
    @(posedge clk); #1;
    req0_valid[0] = 1'b1;
    req1_valid[0] = 1'b1;
    req0_s[0]     = vecs[2].o0;
    req1_s[0]     = vecs[2].o1;
    rsp_ready[0]  = 1'b1;
    for (int k = 0; k < 80 && ids.size() < 4; k++) begin
      @(negedge clk);
      if (rsp_valid[0] && rsp_ready[0]) ids.push_back(int'(rsp_id[0]));
    end
    @(posedge clk); #1;
    req0_valid[0] = 1'b0;
    req1_valid[0] = 1'b0;
    repeat (8) @(posedge clk);
    #1 rsp_ready[0] = 1'b0;
    chk("alt_count", 64'(ids.size()), 64'(4));
    for (int k = 0; k < ids.size(); k++)
      chk($sformatf("alt_id%0d", k), 64'(ids[k]), 64'(k % 2));

    // Stall in RESP with rsp_ready low for five cycles.
    @(posedge clk); #1;
    req0_valid[0] = 1'b1;
    req0_s[0]     = {16'h0123, 16'h4567, 16'h89AB, 4'h9};
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = req0_ready[0];
    end
    chk("stall_accept", 64'(got), 64'(1));
    @(posedge clk); #1;
    req0_valid[0] = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = rsp_valid[0];
    end
    chk("stall_rsp_seen", 64'(got), 64'(1));
    snap_res = rsp_result[0];
    snap_fl  = rsp_flags[0];
    snap_id  = rsp_id[0];
    @(posedge clk); #1;
    req1_valid[0] = 1'b1;
    req1_s[0]     = {16'h0F00, 16'h00F0, 16'h000F, 4'h2};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_valid", 64'(rsp_valid[0]), 64'(1));
      chk("stall_outputs", 64'({snap_id, snap_fl, snap_res}),
          64'({rsp_id[0], rsp_flags[0], rsp_result[0]}));
      chk("stall_ready", 64'({req1_ready[0], req0_ready[0]}), 64'(0));
      if (k < 4) @(posedge clk);
    end
    @(posedge clk); #1;
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0;
    @(negedge clk);
    chk("stall_release_idle", 64'(rsp_valid[0]), 64'(0));
    chk("stall_release_grant", 64'(req1_ready[0]), 64'(1));
    @(posedge clk); #1;
    req1_valid[0] = 1'b0;
    rsp_ready[0]  = 1'b1;
    repeat (6) @(posedge clk);
    #1 rsp_ready[0] = 1'b0;

    // Reset during the second BUSY cycle discards the operation.
    @(posedge clk); #1;
    req0_valid[0] = 1'b1;
    req0_s[0]     = {16'h0101, 16'h0202, 16'h0303, 4'h8};
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = req0_ready[0];
    end
    chk("busy_reset_accept", 64'(got), 64'(1));
    @(posedge clk); #1;
    req0_valid[0] = 1'b0;
    @(posedge clk); #1;
    reset[0] = 1'b1;
    @(negedge clk);
    chk_zero(0, "busy_reset");
    @(posedge clk); #1;
    reset[0]     = 1'b0;
    rsp_ready[0] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("busy_reset_no_rsp", 64'(rsp_valid[0]), 64'(0));
    end
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0;
    do_op(0, 0, 1, z_op, {16'h1234, 16'h0001, 16'h0000, 4'h0}, id, res, fl, acc_wait, lat);
    chk("after_reset_id", 64'(id), 64'(1));
    chk("after_reset_result", 64'(res), 64'(16'h1235));

    // Lone req1 after reset is granted at once despite the pointer.
    do_reset(0);
    do_op(0, 0, 1, z_op, {16'hFFFF, 16'h0001, 16'h0000, 4'hF}, id, res, fl, acc_wait, lat);
    chk("lone_req1_wait", 64'(acc_wait), 64'(1));
    chk("lone_req1_id", 64'(id), 64'(1));
    chk("lone_req1_result", 64'(res), 64'(16'hFDFE));

    // Latency extremes.
    do_op(1, 1, 0, {16'h0000, 16'h0000, 16'h0008, 4'h4}, z_op, id, res, fl, acc_wait, lat);
    chk("lat1_latency", 64'(lat), 64'(2));
    chk("lat1_flags", 64'(fl), 64'(4'b1000));
    chk("lat1_result", 64'(res), 64'(16'h0008));
    do_op(2, 1, 0, {16'h0000, 16'h0000, 16'h0008, 4'h4}, z_op, id, res, fl, acc_wait, lat);
    chk("lat15_latency", 64'(lat), 64'(16));
    chk("lat15_flags", 64'(fl), 64'(4'b1000));
    chk("lat15_result", 64'(res), 64'(16'h0008));

    // Random traffic on the LATENCY=2 instance, checked by the model.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      a0 = req0_valid[0] && req0_ready[0];
      a1 = req1_valid[0] && req1_ready[0];
      @(posedge clk); #1;
      if (a0 || !req0_valid[0]) begin
        req0_valid[0] = 1'($urandom_range(0, 1));
        req0_s[0]     = rand_op();
      end
      if (a1 || !req1_valid[0]) begin
        req1_valid[0] = 1'($urandom_range(0, 1));
        req1_s[0]     = rand_op();
      end
      rsp_ready[0] = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    @(posedge clk); #1;
    req0_valid[0] = 1'b0;
    req1_valid[0] = 1'b0;
    rsp_ready[0]  = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("drain_idle", 64'(rsp_valid[0]), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
